// File: rtl/imem_loader.sv
// Program loader: assembles CHUNK_W-bit chunks (LSB chunk first) into WORD_W-bit words and writes them to instruction memory.
// Latency: wr_en one cycle after a word's final chunk is accepted; done rises with the terminating write.
// Backpressure: none; in_valid qualifies each chunk, idle gaps are free, chunks after done are dropped and flag err.
module imem_loader #(
  parameter int CHUNK_W = 5,
  parameter int WORD_W  = 15,
  parameter int DEPTH   = 8,
  localparam int NCHUNK = (WORD_W + CHUNK_W - 1) / CHUNK_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [WORD_W-1:0]  wr_data,
  output logic               done,
  output logic [ADDR_W:0]    words_loaded,
  output logic [WORD_W-1:0]  checksum,
  output logic               err
);

  // Assembly register spans whole chunks; bits above WORD_W are simply never written out.
  localparam int TOT_W = NCHUNK * CHUNK_W;
  localparam int CC_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CC_W-1:0]   CC_LAST   = CC_W'(NCHUNK - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {LOAD, DONE} state_t;

  state_t            state;
  logic [CC_W-1:0]   cc;
  logic [TOT_W-1:0]  word;
  logic [TOT_W-1:0]  word_next;
  logic [ADDR_W-1:0] addr;

  // Merge the incoming chunk into its little-endian slot of the partial word.
  always_comb begin
    word_next = word;
    word_next[cc*CHUNK_W +: CHUNK_W] = in_data;
  end

  // Loader FSM: chunk assembly, memory write strobe, bookkeeping and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      cc           <= '0;
      word         <= '0;
      addr         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      done         <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
      err          <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (cc == CC_LAST) begin
              cc           <= '0;
              word         <= '0;
              wr_en        <= 1'b1;
              wr_addr      <= addr;
              wr_data      <= word_next[WORD_W-1:0];
              addr         <= addr + 1'b1;
              words_loaded <= words_loaded + 1'b1;
              checksum     <= checksum ^ word_next[WORD_W-1:0];
              // in_last only counts on the final chunk; a full memory also ends the load.
              if (in_last || addr == ADDR_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              cc   <= cc + 1'b1;
              word <= word_next;
            end
          end
        end
        DONE: begin
          if (in_valid) err <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        in_valid = 1'b0;
  logic [4:0]  in_data  = '0;
  logic        in_last  = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [14:0] wr_data;
  logic        done;
  logic [3:0]  words_loaded;
  logic [14:0] checksum;
  logic        err;

  // CHUNK_W=4, WORD_W=16, DEPTH=4 instance
  logic        in_valid2 = 1'b0;
  logic [3:0]  in_data2  = '0;
  logic        in_last2  = 1'b0;
  logic        wr_en2;
  logic [1:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic        done2;
  logic [2:0]  words_loaded2;
  logic [15:0] checksum2;
  logic        err2;

  int errors = 0;
  int checks = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
    .words_loaded(words_loaded), .checksum(checksum), .err(err)
  );

  imem_loader #(.CHUNK_W(4), .WORD_W(16), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .done(done2),
    .words_loaded(words_loaded2), .checksum(checksum2), .err(err2)
  );

  // Present inputs, let one rising edge pass, return at the following falling edge.
  task automatic drive(input logic v, input logic [4:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
    @(negedge clk);
  endtask

  task automatic drive2(input logic v, input logic [3:0] d);
    in_valid2 = v; in_data2 = d; in_last2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 3'd0)    begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 15'd0)   begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (words_loaded !== 4'd0) begin errors++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    checks++; if (checksum !== 15'd0)  begin errors++; $display("FAIL reset_checksum got %h want 0", checksum); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_single_word();
    drive(1'b1, 5'h14, 1'b0);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_early_wr_en got %b want 0", wr_en); end
    drive(1'b1, 5'h11, 1'b0);
    drive(1'b1, 5'h04, 1'b1);
    checks++; if (wr_en !== 1'b1)         begin errors++; $display("FAIL single_wr_en got %b want 1", wr_en); end
    checks++; if (wr_addr !== 3'd0)       begin errors++; $display("FAIL single_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 15'h1234)   begin errors++; $display("FAIL single_wr_data got %h want 1234", wr_data); end
    checks++; if (done !== 1'b1)          begin errors++; $display("FAIL single_done got %b want 1", done); end
    checks++; if (words_loaded !== 4'd1)  begin errors++; $display("FAIL single_words got %0d want 1", words_loaded); end
    checks++; if (checksum !== 15'h1234)  begin errors++; $display("FAIL single_checksum got %h want 1234", checksum); end
    drive(1'b0, 5'h00, 1'b0);
    checks++; if (wr_en !== 1'b0)         begin errors++; $display("FAIL single_pulse_width got %b want 0", wr_en); end
    checks++; if (wr_data !== 15'h1234)   begin errors++; $display("FAIL single_data_hold got %h want 1234", wr_data); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 5'h1F, 1'b0);
    checks++; if (err !== 1'b1)          begin errors++; $display("FAIL ovf_err got %b want 1", err); end
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL ovf_wr_en got %b want 0", wr_en); end
    checks++; if (words_loaded !== 4'd1) begin errors++; $display("FAIL ovf_words got %0d want 1", words_loaded); end
    // A full word's worth of chunks after done must not write anything.
    drive(1'b1, 5'h1F, 1'b1);
    drive(1'b1, 5'h1F, 1'b1);
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL ovf_word_wr_en got %b want 0", wr_en); end
    drive(1'b0, 5'h00, 1'b0);
    drive(1'b0, 5'h00, 1'b0);
    checks++; if (err !== 1'b1)          begin errors++; $display("FAIL ovf_sticky got %b want 1", err); end
    checks++; if (wr_addr !== 3'd0)      begin errors++; $display("FAIL ovf_addr_frozen got %0d want 0", wr_addr); end
    checks++; if (checksum !== 15'h1234) begin errors++; $display("FAIL ovf_checksum got %h want 1234", checksum); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] csum;
    csum = '0;
    do_reset();
    for (int w = 1; w <= 8; w++) begin
      csum = csum ^ 15'(w);
      drive(1'b1, 5'(w), 1'b0);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_gap_wr_en word %0d got %b want 0", w, wr_en); end
      drive(1'b1, 5'h00, 1'b0);
      drive(1'b1, 5'h00, 1'b0);
      checks++; if (wr_en !== 1'b1)            begin errors++; $display("FAIL b2b_wr_en word %0d got %b want 1", w, wr_en); end
      checks++; if (wr_addr !== 3'(w - 1))     begin errors++; $display("FAIL b2b_addr word %0d got %0d want %0d", w, wr_addr, w - 1); end
      checks++; if (wr_data !== 15'(w))        begin errors++; $display("FAIL b2b_data word %0d got %h want %h", w, wr_data, w); end
      checks++; if (done !== (w == 8))         begin errors++; $display("FAIL b2b_done word %0d got %b want %b", w, done, (w == 8)); end
      checks++; if (words_loaded !== 4'(w))    begin errors++; $display("FAIL b2b_words word %0d got %0d want %0d", w, words_loaded, w); end
    end
    checks++; if (checksum !== 15'h0008) begin errors++; $display("FAIL b2b_checksum got %h want 0008", checksum); end
    checks++; if (csum !== checksum)     begin errors++; $display("FAIL b2b_checksum_model got %h want %h", checksum, csum); end
    drive(1'b1, 5'h01, 1'b0);
    checks++; if (err !== 1'b1)          begin errors++; $display("FAIL b2b_post_err got %b want 1", err); end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    do_reset();
    // in_last on a non-final chunk must be ignored.
    drive(1'b1, 5'h14, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 5'h1F, 1'b1);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL gap1_wr_en idle %0d got %b want 0", k, wr_en); end
    end
    drive(1'b1, 5'h11, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 5'h00, 1'b0);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL gap2_wr_en idle %0d got %b want 0", k, wr_en); end
    end
    drive(1'b1, 5'h04, 1'b0);
    checks++; if (wr_en !== 1'b1)        begin errors++; $display("FAIL gap_wr_en got %b want 1", wr_en); end
    checks++; if (wr_data !== 15'h1234)  begin errors++; $display("FAIL gap_wr_data got %h want 1234", wr_data); end
    checks++; if (wr_addr !== 3'd0)      begin errors++; $display("FAIL gap_wr_addr got %0d want 0", wr_addr); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL gap_done got %b want 0", done); end
    drive(1'b0, 5'h00, 1'b0);
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL gap_after_wr_en got %b want 0", wr_en); end
  endtask

  task automatic test_reset_mid_word();
    // Address is 1 here; two chunks of the second word are accepted.
    drive(1'b1, 5'h03, 1'b0);
    drive(1'b1, 5'h03, 1'b0);
    // Reset coincides with what would be the final chunk: no write may occur.
    rst = 1'b1;
    drive(1'b1, 5'h03, 1'b1);
    rst = 1'b0;
    checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL rstmid_wr_en got %b want 0", wr_en); end
    checks++; if (words_loaded !== 4'd0) begin errors++; $display("FAIL rstmid_words got %0d want 0", words_loaded); end
    checks++; if (checksum !== 15'd0)    begin errors++; $display("FAIL rstmid_checksum got %h want 0", checksum); end
    drive(1'b1, 5'h1F, 1'b0);
    drive(1'b1, 5'h1F, 1'b0);
    drive(1'b1, 5'h1F, 1'b1);
    checks++; if (wr_en !== 1'b1)        begin errors++; $display("FAIL rstmid_wr_en2 got %b want 1", wr_en); end
    checks++; if (wr_addr !== 3'd0)      begin errors++; $display("FAIL rstmid_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 15'h7FFF)  begin errors++; $display("FAIL rstmid_data got %h want 7fff", wr_data); end
    checks++; if (checksum !== 15'h7FFF) begin errors++; $display("FAIL rstmid_checksum2 got %h want 7fff", checksum); end
    checks++; if (words_loaded !== 4'd1) begin errors++; $display("FAIL rstmid_words2 got %0d want 1", words_loaded); end
    checks++; if (done !== 1'b1)         begin errors++; $display("FAIL rstmid_done got %b want 1", done); end
    in_valid = 1'b0;
  endtask

  task automatic test_params_4_16_4();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      drive2(1'b1, 4'hD);
      drive2(1'b1, 4'hC);
      drive2(1'b1, 4'hB);
      checks++; if (wr_en2 !== 1'b0) begin errors++; $display("FAIL p_gap_wr_en word %0d got %b want 0", w, wr_en2); end
      drive2(1'b1, 4'hA);
      checks++; if (wr_en2 !== 1'b1)         begin errors++; $display("FAIL p_wr_en word %0d got %b want 1", w, wr_en2); end
      checks++; if (wr_addr2 !== 2'(w))      begin errors++; $display("FAIL p_addr word %0d got %0d want %0d", w, wr_addr2, w); end
      checks++; if (wr_data2 !== 16'hABCD)   begin errors++; $display("FAIL p_data word %0d got %h want abcd", w, wr_data2); end
      checks++; if (done2 !== (w == 3))      begin errors++; $display("FAIL p_done word %0d got %b want %b", w, done2, (w == 3)); end
    end
    checks++; if (checksum2 !== 16'h0000)    begin errors++; $display("FAIL p_checksum got %h want 0000", checksum2); end
    checks++; if (words_loaded2 !== 3'd4)    begin errors++; $display("FAIL p_words got %0d want 4", words_loaded2); end
    drive2(1'b0, 4'h0);
    checks++; if (err2 !== 1'b0)             begin errors++; $display("FAIL p_err got %b want 0", err2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_overflow();
    test_back_to_back();
    test_gaps();
    test_reset_mid_word();
    test_params_4_16_4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised program loader for the tinysoc family. It assembles instruction words from narrow chunks on a pin-limited input bus and writes them sequentially into the instruction memory. When loading finishes it raises `done`, which enables the CPU. This generation adds:
- configurable chunk width, word width and depth,
- a `in_valid` qualifier, so chunks need not arrive every clock,
- early termination via `in_last`,
- a running XOR checksum and a sticky overflow error.

## Interface
Parameters:
- `CHUNK_W`, default 5: width of one input chunk.
- `WORD_W`, default 15: instruction word width.
- `DEPTH`, default 8: number of instruction memory words; must be ≥ 2.
- Derived parameter `NCHUNK` = ceil(`WORD_W`/`CHUNK_W`): chunks per word.
- Derived parameter `ADDR_W` = clog2(`DEPTH`).

Ports:
- Reset: `rst`, synchronous, active-high. Clock: `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the chunk on `in_data` is accepted this cycle.
- `in_data`  in  `CHUNK_W`  chunk payload.
- `in_last`  in  1  ends the program after the current word; meaningful only together with the word's final chunk.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  `ADDR_W`  instruction memory write address.
- `wr_data`  out  `WORD_W`  assembled instruction word.
- `done`  out  1  load complete; CPU enable; level.
- `words_loaded`  out  `ADDR_W`+1  count of words written.
- `checksum`  out  `WORD_W`  XOR of all words written.
- `err`  out  1  sticky; a chunk arrived after `done`.

## Operation
- Two states:
  - **LOAD**, entered on reset.
  - **DONE**, terminal until `rst`.
- Chunk counter `cc`, range 0..`NCHUNK`-1, and a word shift register.
- In LOAD, each cycle with `in_valid`=1:
  - `in_data` is placed at bits [`cc`·`CHUNK_W` +: `CHUNK_W`] of the word.
  - Bits at or above `WORD_W` in the final chunk are discarded.
  - Chunks are little-endian: the first chunk received is the LSBs.
- Cycles with `in_valid`=0 change nothing. Gaps of any length are legal.
- Final chunk accepted (`cc`=`NCHUNK`-1):
  - The next cycle, `wr_en`=1 with `wr_data` = assembled word and `wr_addr` = current address.
  - The same cycle, the address increments, `words_loaded` increments, and `checksum` ^= word.
  - `cc` returns to 0.
- Termination: the final chunk is accepted with `in_last`=1, or the written word is at address `DEPTH`-1. The FSM then enters DONE. `done` rises in the same cycle as that word's `wr_en`.
- `in_last` on a non-final chunk is ignored.
- In DONE:
  - `in_valid`=1 sets `err`=1; the chunk is discarded.
  - No further `wr_en`; the address is frozen.
- Unwritten memory words keep their reset contents (the memory resets to 0).
- Reset mid-operation discards any partial word, returns the address and `cc` to 0, and returns the FSM to LOAD.

## Timing
- All outputs are registered.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `words_loaded`=0, `checksum`=0, `err`=0.
- Latency: 1 cycle from acceptance of a word's final chunk to `wr_en`.
- `wr_en` is a single-cycle pulse. `wr_addr`/`wr_data` are valid while `wr_en`=1 and hold afterwards.
- Minimum word period is `NCHUNK` cycles. Back-to-back words give `wr_en` every `NCHUNK` cycles.
- `checksum` and `words_loaded` reflect the written word in the same cycle as `wr_en`.
- `rst` overrides all inputs in the same cycle, including `in_valid` with the final chunk: no write occurs.
- With `NCHUNK`=1 every valid chunk is a whole word, giving `wr_en` 1 cycle after each chunk.

## Test plan
- **Default parameters, single word:** chunks 0x14, 0x11, 0x04 with `in_valid` held, then `in_last`=1 on the third chunk. Required response: 1 cycle later, `wr_en`=1, `wr_addr`=0, `wr_data`=0x1234, `done`=1, `words_loaded`=1, `checksum`=0x1234.
- **Full load:** 8 words 0x0001..0x0008, `in_last`=0 throughout. Required response: 8 `wr_en` pulses at addresses 0..7; `done` rises with the 8th pulse; `words_loaded`=8; `checksum`=0x0008.
- **Gaps:** the same 3 chunks with 2 idle cycles between each. Required response: `wr_data`=0x1234; `wr_en` exactly 1 cycle after the third chunk; no other strobes.
- **Overflow:** after `done`, drive `in_valid` with 0x1F. Required response: `err`=1 next cycle and stays 1; no `wr_en`; `words_loaded` unchanged.
- **Reset mid-word:** 2 chunks of word 1 accepted, then `rst` for 1 cycle, then a full word 0x7FFF. Required response: write at `wr_addr`=0 with 0x7FFF; `checksum`=0x7FFF; `words_loaded`=1.
- **Parameters `CHUNK_W`=4, `WORD_W`=16, `DEPTH`=4:** chunks 0xD, 0xC, 0xB, 0xA, repeated 4 times. Required response: `wr_data`=0xABCD at addresses 0..3; `done` with the 4th pulse; `checksum`=0x0000.
